pwm_duty_ramp: RTL and testbench

Slew-rate-limited duty sequencer that drives the duty input of the pwm block.
- Accepts a target duty and step size over a valid/ready handshake.
- Moves its duty output toward the target by at most one step per PWM period, updating only on period boundaries so the output never glitches mid-period.
- Used for soft-start and soft-stop of motor and LED loads in the HIL design.

---
 rtl/pwm_ramp_pkg.sv | 13 +
 rtl/pwm_ramp_step.sv | 31 +++
 rtl/pwm_duty_ramp.sv | 116 +++++++++++
 tb/tb_pwm_duty_ramp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_pkg.sv
// rtl/pwm_ramp_pkg.sv - shared types and constants for the pwm duty ramp sequencer
package pwm_ramp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest usable increment; a requested step of 0 is promoted to this.
  localparam int unsigned STEP_MIN = 1;

endpackage

// File: rtl/pwm_ramp_step.sv
// rtl/pwm_ramp_step.sv - combinational saturating stepper moving duty toward target
module pwm_ramp_step #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic [WIDTH-1:0]  duty_i,
  input  logic [WIDTH-1:0]  target_i,
  input  logic [STEP_W-1:0] step_i,
  output logic [WIDTH-1:0]  next_o
);

  logic signed [WIDTH:0] diff;
  logic        [WIDTH:0] mag;
  logic        [WIDTH-1:0] step_w;

  // Land exactly on the target when within one step, otherwise move one step
  // toward it; since |diff| > step in that branch the result cannot wrap.
  always_comb begin
    diff   = $signed({1'b0, target_i}) - $signed({1'b0, duty_i});
    mag    = diff[WIDTH] ? unsigned'(-diff) : unsigned'(diff);
    step_w = WIDTH'(step_i);
    if (mag <= {1'b0, step_w}) begin
      next_o = target_i;
    end else if (diff[WIDTH]) begin
      next_o = duty_i - step_w;
    end else begin
      next_o = duty_i + step_w;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slew-limited duty sequencer; optional abort via PWM_DUTY_RAMP_ABORT_EN
module pwm_duty_ramp
  import pwm_ramp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              period_start,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [WIDTH-1:0]  tgt_duty,
  input  logic [STEP_W-1:0] tgt_step,
`ifdef PWM_DUTY_RAMP_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic [WIDTH-1:0]  duty,
  output logic              busy,
  output logic              done
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    duty_q, duty_d;
  logic [WIDTH-1:0]    target_q, target_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [WIDTH-1:0]    step_next;
`ifdef PWM_DUTY_RAMP_ABORT_EN
  logic                aborted_q, aborted_d;
`endif

  pwm_ramp_step #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_step (
    .duty_i   (duty_q),
    .target_i (target_q),
    .step_i   (step_q),
    .next_o   (step_next)
  );

  // Next-state logic: accept in IDLE, step on enabled period boundaries in RAMP.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
`ifdef PWM_DUTY_RAMP_ABORT_EN
    aborted_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Accepting is allowed even with enable low; only ramp progress freezes.
        if (tgt_valid) begin
          target_d = tgt_duty;
          step_d   = (tgt_step == '0) ? STEP_W'(STEP_MIN) : tgt_step;
          state_d  = RAMP;
        end
      end
      RAMP: begin
`ifdef PWM_DUTY_RAMP_ABORT_EN
        // Abort is an override: it wins over a step and acts even when frozen.
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else
`endif
        if (enable) begin
          if (duty_q == target_q) begin
            state_d = DONE;
          end else if (period_start) begin
            duty_d = step_next;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= STEP_W'(STEP_MIN);
`ifdef PWM_DUTY_RAMP_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
`ifdef PWM_DUTY_RAMP_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q == RAMP);
  assign done      = (state_q == DONE);
  assign duty      = duty_q;
`ifdef PWM_DUTY_RAMP_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - self-checking bench for pwm_duty_ramp with a behavioural ramp model
module tb_pwm_duty_ramp;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              period_start;
  logic              tgt_valid;
  logic              tgt_ready;
  logic [WIDTH-1:0]  tgt_duty;
  logic [STEP_W-1:0] tgt_step;
  logic [WIDTH-1:0]  duty;
  logic              busy;
  logic              done;
`ifdef PWM_DUTY_RAMP_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: current duty, latched target/step, ramp in progress.
  int m_duty   = 0;
  int m_target = 0;
  int m_step   = 1;
  bit m_ramp   = 1'b0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .period_start (period_start),
    .tgt_valid    (tgt_valid),
    .tgt_ready    (tgt_ready),
    .tgt_duty     (tgt_duty),
    .tgt_step     (tgt_step),
`ifdef PWM_DUTY_RAMP_ABORT_EN
    .abort        (abort),
    .aborted      (aborted),
`endif
    .duty         (duty),
    .busy         (busy),
    .done         (done)
  );

  function automatic int step_ref(input int d, input int t, input int s);
    int gap;
    gap = (t > d) ? (t - d) : (d - t);
    if (gap <= s) return t;
    return (t > d) ? (d + s) : (d - s);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input int t, input int s, input bit with_pulse);
    check("ready_before_accept", {31'd0, tgt_ready}, 32'd1);
    tgt_valid    = 1'b1;
    tgt_duty     = t[WIDTH-1:0];
    tgt_step     = s[STEP_W-1:0];
    period_start = with_pulse;
    @(negedge clk);
    tgt_valid    = 1'b0;
    period_start = 1'b0;
    tgt_duty     = WIDTH'($urandom);
    tgt_step     = STEP_W'($urandom);
    m_target = t;
    m_step   = (s == 0) ? 1 : s;
    m_ramp   = 1'b1;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("duty_after_accept", 32'(duty), 32'(m_duty));
  endtask

  task automatic pulse();
    period_start = 1'b1;
    @(negedge clk);
    period_start = 1'b0;
    if (m_ramp && enable) m_duty = step_ref(m_duty, m_target, m_step);
    check("duty_after_period", 32'(duty), 32'(m_duty));
  endtask

  task automatic finish_ramp();
    check("done_not_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("ready_in_done", {31'd0, tgt_ready}, 32'd0);
    check("duty_at_done", 32'(duty), 32'(m_target));
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("ready_after_done", {31'd0, tgt_ready}, 32'd1);
    m_ramp = 1'b0;
  endtask

  task automatic run_ramp(input int t, input int s, input int gap_lo, input int gap_hi,
                          input bit spur, input bit with_pulse);
    int g;
    int guard;
    accept(t, s, with_pulse);
    guard = 0;
    while (m_duty != m_target && guard < 300) begin
      g = $urandom_range(gap_hi, gap_lo);
      for (int i = 0; i < g; i++) begin
        tgt_valid = spur && (i == 0);
        tgt_duty  = WIDTH'($urandom);
        @(negedge clk);
        tgt_valid = 1'b0;
      end
      check("busy_mid_ramp", {31'd0, busy}, 32'd1);
      pulse();
      guard++;
    end
    finish_ramp();
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b1;
    period_start = 1'b0;
    tgt_valid    = 1'b0;
    tgt_duty     = '0;
    tgt_step     = '0;
`ifdef PWM_DUTY_RAMP_ABORT_EN
    abort        = 1'b0;
`endif
    tick(3);
    check("reset_duty", 32'(duty), 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    tick(1);
    check("ready_after_reset", {31'd0, tgt_ready}, 32'd1);

    // Soft-start 0 -> 100 in steps of 10, one period every 256 clocks.
    run_ramp(100, 10, 255, 255, 1'b0, 1'b0);
    check("up_final", 32'(duty), 32'd100);

    // Ramp down with a final partial step, no underflow.
    run_ramp(5, 30, 1, 4, 1'b1, 1'b0);
    check("down_final", 32'(duty), 32'd5);

    // Target equal to current duty completes without a period boundary.
    accept(5, 7, 1'b0);
    finish_ramp();

    // Saturation at the top of the range.
    run_ramp(250, 255, 0, 3, 1'b0, 1'b0);
    accept(255, 200, 1'b0);
    pulse();
    check("sat_top", 32'(duty), 32'd255);
    finish_ramp();

    // Randomized targets/steps, including step 0 and a coincident period_start at accept.
    for (int k = 0; k < 8; k++) begin
      int t;
      int s;
      t = int'($urandom_range(255, 0));
      s = (k == 3) ? 0 : int'($urandom_range(80, 1));
      if (s == 0) t = (m_duty < 200) ? m_duty + 20 : m_duty - 20;
      run_ramp(t, s, 0, 5, 1'b1, bit'($urandom_range(1, 0)));
    end

    // Enable low freezes the ramp across several periods.
    run_ramp(0, 255, 0, 2, 1'b0, 1'b0);
    accept(200, 20, 1'b0);
    pulse();
    pulse();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(3);
      pulse();
    end
    check("frozen_duty", 32'(duty), 32'd40);
    check("frozen_busy", {31'd0, busy}, 32'd1);
    enable = 1'b1;
    tick(2);
    pulse();
    check("resume_duty", 32'(duty), 32'd60);

    // Reset mid-ramp discards the ramp with no done pulse.
    pulse();
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    m_duty = 0; m_target = 0; m_step = 1; m_ramp = 1'b0;
    check("midreset_duty", 32'(duty), 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ready", {31'd0, tgt_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("midreset_no_done", {31'd0, done}, 32'd0);
      tick(1);
    end
    pulse();

`ifdef PWM_DUTY_RAMP_ABORT_EN
    // Abort together with a period boundary at duty 40 heading to 100.
    accept(100, 20, 1'b0);
    pulse();
    pulse();
    abort        = 1'b1;
    period_start = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    period_start = 1'b0;
    m_ramp = 1'b0;
    check("abort_duty", 32'(duty), 32'd40);
    check("abort_pulse", {31'd0, aborted}, 32'd1);
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_ready", {31'd0, tgt_ready}, 32'd1);
    @(negedge clk);
    check("abort_one_cycle", {31'd0, aborted}, 32'd0);
    check("abort_no_done_later", {31'd0, done}, 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle_ignored", {31'd0, aborted}, 32'd0);
    pulse();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
